// File: rtl/pe_group_acc_collector.sv
// ---------------------------------------------------------------------------
// pe_group_acc_collector
//
// Collects partial sums from a group of PE-row output channels. Each channel
// accumulates a programmable number of samples (latched from AccLen on its
// first sample), then holds the result in a FULL state until a strict
// round-robin output port drains it. The output pointer never skips a channel,
// so results leave in channel order 0,1,...,ChannelCount-1, repeating.
//
// Ports:
//   clk             rising-edge clock
//   aclr            synchronous, active-high reset
//   AccLen          requested accumulation length (0 -> 1, clamped to MaxAccCount)
//   DataInValid     per-channel input valid
//   DataIn          per-channel partial sums, channel k at [k*DataWidth +: DataWidth]
//   DataInRdy       per-channel input ready (high while the channel accumulates)
//   DataOutValid    result valid (channel under the pointer is FULL)
//   DataOutRdy      downstream ready
//   DataOut         accumulated result of the channel under the pointer
//   DataOutChannel  round-robin pointer, i.e. source channel of DataOut
//   Busy            any channel mid-accumulation or holding a result
// ---------------------------------------------------------------------------
module pe_group_acc_collector #(
  parameter int DataWidth        = 32,
  parameter int ChannelCount     = 4,
  parameter int ChannelAddrWidth = 2,
  parameter int MaxAccCount      = 16,
  parameter int AccCountWidth    = 5
) (
  input  logic                              clk,
  input  logic                              aclr,
  input  logic [AccCountWidth-1:0]          AccLen,
  input  logic [ChannelCount-1:0]           DataInValid,
  input  logic [ChannelCount*DataWidth-1:0] DataIn,
  output logic [ChannelCount-1:0]           DataInRdy,
  output logic                              DataOutValid,
  input  logic                              DataOutRdy,
  output logic [DataWidth-1:0]              DataOut,
  output logic [ChannelAddrWidth-1:0]       DataOutChannel,
  output logic                              Busy
);

  typedef enum logic {
    Accum = 1'b0,
    Full  = 1'b1
  } chanState_e;

  localparam logic [AccCountWidth-1:0]    MaxLen   = AccCountWidth'(MaxAccCount);
  localparam logic [AccCountWidth-1:0]    OneCnt   = AccCountWidth'(1);
  localparam logic [ChannelAddrWidth-1:0] LastChan = ChannelAddrWidth'(ChannelCount - 1);
  localparam logic [ChannelAddrWidth-1:0] OnePtr   = ChannelAddrWidth'(1);

  chanState_e                  state  [ChannelCount];
  logic [AccCountWidth-1:0]    cnt    [ChannelCount];
  logic [AccCountWidth-1:0]    len    [ChannelCount];
  logic [DataWidth-1:0]        sum    [ChannelCount];
  logic [ChannelAddrWidth-1:0] ptr;

  logic [AccCountWidth-1:0]    clampedLen;
  logic [AccCountWidth-1:0]    effLen [ChannelCount];
  logic [ChannelCount-1:0]     accept;
  logic [ChannelCount-1:0]     drain;
  logic [ChannelCount-1:0]     lastSample;
  logic [ChannelCount-1:0]     busyVec;
  logic                        handshake;

  // Length a channel would latch if it took its first sample this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    clampedLen = AccLen;
    if (AccLen == '0) begin
      clampedLen = OneCnt;
    end else if (AccLen > MaxLen) begin
      clampedLen = MaxLen;
    end
  end

  // Ready, busy and the output port depend on registered state only.
  always_comb begin
    DataInRdy = '0;
    busyVec   = '0;
    for (int k = 0; k < ChannelCount; k++) begin
      DataInRdy[k] = (state[k] == Accum);
      busyVec[k]   = (cnt[k] != '0) || (state[k] == Full);
    end
  end

  assign Busy           = |busyVec;
  assign DataOutValid   = (state[ptr] == Full);
  assign DataOut        = sum[ptr];
  assign DataOutChannel = ptr;
  assign handshake      = DataOutValid && DataOutRdy;

  // Per-channel accept/drain decode. A sample on cnt==0 uses the freshly
  // clamped AccLen; later samples compare against the latched length so
  // AccLen changes mid-accumulation are ignored.
  always_comb begin
    accept     = DataInValid & DataInRdy;
    drain      = '0;
    drain[ptr] = handshake;
    lastSample = '0;
    for (int k = 0; k < ChannelCount; k++) begin
      effLen[k]     = (cnt[k] == '0) ? clampedLen : len[k];
      lastSample[k] = ((cnt[k] + OneCnt) == effLen[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      // NOTE: the sum array is reset along with the control state because a
      // freshly reset channel must present DataOut=0 through the output mux.
      for (int k = 0; k < ChannelCount; k++) begin
        state[k] <= Accum;
        cnt[k]   <= '0;
        sum[k]   <= '0;
        len[k]   <= OneCnt;
      end
      ptr <= '0;
    end else begin
      for (int k = 0; k < ChannelCount; k++) begin
        // Accept and drain are exclusive: accept needs ACCUM, drain needs FULL,
        // so a drained channel can take its next sample one cycle later.
        if (accept[k]) begin
          if (cnt[k] == '0) begin
            len[k] <= clampedLen;
            sum[k] <= DataIn[k*DataWidth +: DataWidth];
          end else begin
            // Modulo-2^DataWidth accumulation, wraps without saturation.
            sum[k] <= sum[k] + DataIn[k*DataWidth +: DataWidth];
          end
          if (lastSample[k]) begin
            state[k] <= Full;
            cnt[k]   <= '0;
          end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            cnt[k] <= cnt[k] + OneCnt;
          end
        end else if (drain[k]) begin
          state[k] <= Accum;
        end
      end
      if (handshake) begin
        ptr <= (ptr == LastChan) ? '0 : ptr + OnePtr;
      end
    end
  end

endmodule

// File: tb/tb_pe_group_acc_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_group_acc_collector
//
// Directed bench for pe_group_acc_collector. Stimulus pushes hand-computed
// expected results (data, channel) into a scoreboard queue; an independent
// monitor pops and compares on every output handshake. Directed checks cover
// reset values, ready/valid timing, pointer order, stall stability and
// mid-operation reset.
// ---------------------------------------------------------------------------
module tb_pe_group_acc_collector;

  localparam int DW  = 32;
  localparam int CC  = 4;
  localparam int CAW = 2;
  localparam int MAC = 16;
  localparam int ACW = 5;

  typedef struct {
    logic [DW-1:0]  data;
    logic [CAW-1:0] ch;
  } expItem_t;

  logic               clk;
  logic               aclr;
  logic [ACW-1:0]     AccLen;
  logic [CC-1:0]      DataInValid;
  logic [CC*DW-1:0]   DataIn;
  logic [CC-1:0]      DataInRdy;
  logic               DataOutValid;
  logic               DataOutRdy;
  logic [DW-1:0]      DataOut;
  logic [CAW-1:0]     DataOutChannel;
  logic               Busy;

  expItem_t sbq[$];
  int       compared;
  int       mismatched;

  pe_group_acc_collector #(
    .DataWidth       (DW),
    .ChannelCount    (CC),
    .ChannelAddrWidth(CAW),
    .MaxAccCount     (MAC),
    .AccCountWidth   (ACW)
  ) dut (
    .clk           (clk),
    .aclr          (aclr),
    .AccLen        (AccLen),
    .DataInValid   (DataInValid),
    .DataIn        (DataIn),
    .DataInRdy     (DataInRdy),
    .DataOutValid  (DataOutValid),
    .DataOutRdy    (DataOutRdy),
    .DataOut       (DataOut),
    .DataOutChannel(DataOutChannel),
    .Busy          (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!aclr && DataOutValid && DataOutRdy) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_unexpected: got data 0x%0h ch %0d with empty scoreboard", DataOut, DataOutChannel);
      end else begin
        expItem_t e;
        e = sbq.pop_front();
        check("sb_data", 64'(DataOut), 64'(e.data));
        check("sb_channel", 64'(DataOutChannel), 64'(e.ch));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [DW-1:0] d, input logic [CAW-1:0] c);
    expItem_t e;
    e.data = d;
    e.ch   = c;
    sbq.push_back(e);
  endtask

  task automatic feed(input int ch, input logic [DW-1:0] val);
    DataInValid              = '0;
    DataInValid[ch]          = 1'b1;
    DataIn[ch*DW +: DW]      = val;
    tick();
    DataInValid              = '0;
  endtask

  task automatic do_reset();
    aclr        = 1'b1;
    DataInValid = '0;
    tick();
    tick();
    aclr = 1'b0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    aclr        = 1'b1;
    AccLen      = '0;
    DataInValid = '0;
    DataIn      = '0;
    DataOutRdy  = 1'b1;

    // Reset values, during reset and on the cycle after it.
    tick();
    tick();
    check("rst_rdy", 64'(DataInRdy), 64'hF);
    check("rst_valid", 64'(DataOutValid), 64'd0);
    check("rst_data", 64'(DataOut), 64'd0);
    check("rst_chan", 64'(DataOutChannel), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    aclr = 1'b0;
    tick();
    check("post_rst_rdy", 64'(DataInRdy), 64'hF);
    check("post_rst_valid", 64'(DataOutValid), 64'd0);
    check("post_rst_busy", 64'(Busy), 64'd0);

    // Channel 0: 1+2+3+4 = 10, valid one cycle after the fourth sample.
    AccLen = 5'd4;
    expect_out(32'd10, 2'd0);
    feed(0, 32'd1);
    check("t1_busy", 64'(Busy), 64'd1);
    feed(0, 32'd2);
    feed(0, 32'd3);
    check("t1_not_full", 64'(DataOutValid), 64'd0);
    feed(0, 32'd4);
    check("t1_valid", 64'(DataOutValid), 64'd1);
    check("t1_data", 64'(DataOut), 64'd10);
    check("t1_chan", 64'(DataOutChannel), 64'd0);
    check("t1_rdy_full", 64'(DataInRdy[0]), 64'd0);
    tick();
    check("t1_rdy_after_drain", 64'(DataInRdy[0]), 64'd1);
    check("t1_ptr_adv", 64'(DataOutChannel), 64'd1);
    check("t1_idle", 64'(Busy), 64'd0);

    // All channels fed k+1 twice in parallel: 2,4,6,8 in channel order.
    do_reset();
    AccLen      = 5'd2;
    DataIn      = {32'd4, 32'd3, 32'd2, 32'd1};
    DataInValid = 4'hF;
    expect_out(32'd2, 2'd0);
    expect_out(32'd4, 2'd1);
    expect_out(32'd6, 2'd2);
    expect_out(32'd8, 2'd3);
    tick();
    tick();
    DataInValid = '0;
    check("t2_all_full_rdy", 64'(DataInRdy), 64'h0);
    for (int k = 0; k < CC; k++) begin
      check("t2_valid", 64'(DataOutValid), 64'd1);
      check("t2_chan", 64'(DataOutChannel), 64'(k));
      check("t2_data", 64'(DataOut), 64'(2 * (k + 1)));
      tick();
    end
    check("t2_wrap", 64'(DataOutChannel), 64'd0);
    check("t2_wrap_valid", 64'(DataOutValid), 64'd0);
    check("t2_rdy_back", 64'(DataInRdy), 64'hF);
    check("t2_busy", 64'(Busy), 64'd0);

    // Channel 2 fills first; pointer waits on channel 0 then channel 1.
    do_reset();
    AccLen = 5'd1;
    expect_out(32'h10, 2'd0);
    expect_out(32'h20, 2'd1);
    expect_out(32'h30, 2'd2);
    feed(2, 32'h30);
    for (int i = 0; i < 3; i++) begin
      check("t3_wait_valid", 64'(DataOutValid), 64'd0);
      check("t3_ch2_held", 64'(DataInRdy[2]), 64'd0);
      tick();
    end
    feed(0, 32'h10);
    check("t3_ch0_valid", 64'(DataOutValid), 64'd1);
    tick();
    check("t3_wait_ch1", 64'(DataOutValid), 64'd0);
    feed(1, 32'h20);
    check("t3_ch1_chan", 64'(DataOutChannel), 64'd1);
    tick();
    check("t3_ch2_valid", 64'(DataOutValid), 64'd1);
    check("t3_ch2_data", 64'(DataOut), 64'h30);
    tick();
    check("t3_ptr3_idle", 64'(DataOutValid), 64'd0);

    // Wrap-around and length clamping.
    do_reset();
    AccLen = 5'd2;
    expect_out(32'h00000001, 2'd0);
    feed(0, 32'hFFFFFFFF);
    feed(0, 32'h00000002);
    check("t4_wrap_data", 64'(DataOut), 64'h1);
    tick();
    AccLen = 5'd0;
    expect_out(32'd7, 2'd1);
    feed(1, 32'd7);
    check("t4_len0_valid", 64'(DataOutValid), 64'd1);
    check("t4_len0_data", 64'(DataOut), 64'd7);
    tick();
    // AccLen above MaxAccCount clamps to 16; later AccLen changes are ignored.
    AccLen = 5'd20;
    expect_out(32'd16, 2'd2);
    feed(2, 32'd1);
    AccLen = 5'd1;
    for (int i = 0; i < 14; i++) feed(2, 32'd1);
    check("t4_clamp_not_full", 64'(DataOutValid), 64'd0);
    check("t4_clamp_rdy", 64'(DataInRdy[2]), 64'd1);
    feed(2, 32'd1);
    check("t4_clamp_valid", 64'(DataOutValid), 64'd1);
    check("t4_clamp_data", 64'(DataOut), 64'd16);
    tick();

    // Output stall: result and channel stable, ready low, inputs ignored.
    do_reset();
    AccLen     = 5'd1;
    DataOutRdy = 1'b0;
    expect_out(32'hABCD, 2'd0);
    feed(0, 32'hABCD);
    DataInValid[0] = 1'b1;
    DataIn[0 +: DW] = 32'h1111;
    for (int i = 0; i < 5; i++) begin
      check("t5_valid", 64'(DataOutValid), 64'd1);
      check("t5_data", 64'(DataOut), 64'hABCD);
      check("t5_chan", 64'(DataOutChannel), 64'd0);
      check("t5_rdy", 64'(DataInRdy[0]), 64'd0);
      tick();
    end
    DataInValid = '0;
    DataOutRdy  = 1'b1;
    tick();
    check("t5_drained", 64'(DataInRdy[0]), 64'd1);
    check("t5_busy", 64'(Busy), 64'd0);

    // Mid-operation reset discards partial state and reset-cycle inputs.
    do_reset();
    AccLen = 5'd4;
    feed(1, 32'd9);
    feed(1, 32'd9);
    check("t6_busy_before", 64'(Busy), 64'd1);
    aclr            = 1'b1;
    DataInValid[1]  = 1'b1;
    DataIn[DW +: DW] = 32'd100;
    tick();
    aclr        = 1'b0;
    DataInValid = '0;
    check("t6_busy_after", 64'(Busy), 64'd0);
    check("t6_valid_after", 64'(DataOutValid), 64'd0);
    check("t6_rdy_after", 64'(DataInRdy), 64'hF);
    expect_out(32'd4, 2'd0);
    expect_out(32'd20, 2'd1);
    DataIn      = {32'd0, 32'd0, 32'd5, 32'd1};
    DataInValid = 4'h3;
    for (int i = 0; i < 4; i++) tick();
    DataInValid = '0;
    check("t6_ch0_data", 64'(DataOut), 64'd4);
    tick();
    check("t6_ch1_chan", 64'(DataOutChannel), 64'd1);
    check("t6_ch1_data", 64'(DataOut), 64'd20);
    tick();

    // Every expected result must have been observed.
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
